spart_tx_mmio: RTL



---
 rtl/spart_tx_mmio_if.sv | 13 +
 rtl/spart_tx_mmio.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_mmio_if.sv
// Data-memory bus slice seen by the SPART TX register window.
// Master is the processor side; slave is the peripheral decoding the window.
interface spart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        en;
  logic        hit;
  logic [31:0] rdata;

  modport master (output addr, wdata, wr, en, input  hit, rdata);
  modport slave  (input  addr, wdata, wr, en, output hit, rdata);
endinterface

// File: rtl/spart_tx_mmio.sv
// Memory-mapped, FIFO-buffered 8N1 SPART transmitter with programmable baud.
// Define SPART_TX_IRQ_EN to build the low-water interrupt and the STATUS.ien bit.
module spart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RST   = 16'h0A2C,
  parameter int          LOW_WATER  = 4
) (
  input  logic           clk,
  input  logic           rst,
  spart_tx_mmio_if.slave bus,
  output logic           txd,
  output logic           irq
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [3:0]      OFF_TXDATA = 4'h0;
  localparam logic [3:0]      OFF_STATUS = 4'h4;
  localparam logic [3:0]      OFF_BAUD   = 4'h8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     count_ext;
  logic [15:0]     baud, timer;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic [3:0]      off;
  logic [31:0]     status;
  logic            wr_txdata, wr_status, wr_baud;
  logic            full, empty, push, pop;
  logic            ovf, ien, idle;
  logic            txd_next, load_bit, shift, bit_end;
  logic            unused_bits;

  // Register window decode
  assign bus.hit   = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.addr[3:0];
  assign wr_txdata = bus.hit & bus.wr & (off == OFF_TXDATA);
  assign wr_status = bus.hit & bus.wr & (off == OFF_STATUS);
  assign wr_baud   = bus.hit & bus.wr & (off == OFF_BAUD);

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  // full is the pre-pop value, so a write while full is dropped even if a pop frees a slot
  assign push  = wr_txdata & ~full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define validity,
  // and a reset-free array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      baud <= BAUD_RST;
    end else begin
      if (wr_txdata & full)                ovf <= 1'b1;
      else if (wr_status & bus.wdata[2])   ovf <= 1'b0;
      if (wr_baud) baud <= bus.wdata[15:0];
    end
  end

`ifdef SPART_TX_IRQ_EN
  localparam logic [CW-1:0] LOW_C = CW'(LOW_WATER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_status) ien <= bus.wdata[3];
      irq <= ien & (count <= LOW_C);
    end
  end
`else
  assign ien = 1'b0;
  assign irq = 1'b0;
`endif

  // Serialiser: state register
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign bit_end = (timer == '0);

  // Serialiser: next state
  // NOTE: each combinational block assigns defaults first so no path leaves a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (!empty)                     state_next = START;
      START: if (bit_end)                    state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_end)                    state_next = empty ? IDLE : START;
      default:                               state_next = IDLE;
    endcase
  end

  // Serialiser: outputs; STOP pops straight into the next START for gapless frames
  always_comb begin
    txd_next = 1'b1;
    pop      = 1'b0;
    load_bit = 1'b0;
    shift    = 1'b0;
    unique case (state)
      IDLE: begin
        pop      = ~empty;
        load_bit = ~empty;
      end
      START: begin
        txd_next = 1'b0;
        load_bit = bit_end;
      end
      DATA: begin
        txd_next = shreg[0];
        load_bit = bit_end;
        shift    = bit_end;
      end
      STOP: begin
        pop      = bit_end & ~empty;
        load_bit = bit_end & ~empty;
      end
      default: ;
    endcase
  end

  // Timer reloads only at bit starts, so a BAUD write never stretches the bit in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd     <= 1'b1;
      timer   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      txd <= txd_next;
      if (load_bit)     timer <= baud;
      else if (!bit_end) timer <= timer - 1'b1;
      if (pop)        shreg <= mem[rd_ptr];
      else if (shift) shreg <= {1'b0, shreg[7:1]};
      if (state == START) bit_idx <= '0;
      else if (shift)     bit_idx <= bit_idx + 1'b1;
    end
  end

  assign idle      = empty & (state == IDLE);
  assign count_ext = 32'(count);
  assign status    = {16'h0, count_ext[7:0], 4'h0, ien, ovf, idle, ~full};

  always_comb begin
    bus.rdata = '0;
    if (bus.hit && bus.en && !bus.wr) begin
      case (off)
        OFF_STATUS: bus.rdata = status;
        OFF_BAUD:   bus.rdata = {16'h0, baud};
        default:    bus.rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^{bus.wdata[31:16]};

endmodule
